// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// reset-domain indices and default timing parameters.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    // Reset domains in release order.
    localparam int STAGE_MEM = 0;
    localparam int STAGE_CPU = 1;
    localparam int STAGE_IO  = 2;

    localparam int DEF_NUM_STAGES      = STAGE_IO + 1;
    localparam int DEF_HOLD_CYCLES     = 16;
    localparam int DEF_GAP_CYCLES      = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Button debouncer: the output level follows the synchronized input only after
// CYCLES consecutive samples disagree with the current level.
`ifdef RESET_SEQ_DEBOUNCE_EN
module debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic CLK_100MHz,
    input  logic RESET_N,
    input  logic SAMPLE,
    output logic LEVEL
);

    localparam int                CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (SAMPLE == level_reg) begin
            cnt_reg   <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            level_reg <= SAMPLE;
            cnt_reg   <= '0;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign LEVEL = level_reg;

endmodule
`endif

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release controller. Define RESET_SEQ_DEBOUNCE_EN to
// route the front-panel button through the debounce sub-module.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                  CLK_100MHz,
    input  logic                  RESET_N,
    input  logic                  BUT,
    input  logic                  SW_REQ,
    output logic [NUM_STAGES-1:0] STAGE_RST,
    output logic                  READY,
    output logic                  BUSY
);

    localparam int               CNT_W     = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int               IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("reset_sequencer: GAP_CYCLES must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("reset_sequencer: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [1:0]            rst_sync_reg;
    logic [1:0]            but_sync_reg;
    logic                  but_level;
    logic                  but_prev_reg;
    logic                  but_req;
    logic                  restart_req;

    seq_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [NUM_STAGES-1:0] stage_rst_reg, stage_rst_next;
    logic                  ready_reg, ready_next;
    logic                  busy_reg, busy_next;

    logic [NUM_STAGES-1:0] stage_hit;
    logic                  hold_done;
    logic                  gap_done;
    logic                  last_stage;

    // The hold counter advances once the first synchronizer flop is high;
    // a metastable first flop can only shift that by one count. The release
    // itself waits for the fully synchronized flag.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            but_sync_reg <= 2'b00;
            but_prev_reg <= 1'b0;
        end else begin
            but_sync_reg <= {but_sync_reg[0], BUT};
            but_prev_reg <= but_level;
        end
    end

`ifdef RESET_SEQ_DEBOUNCE_EN
    debounce #(
        .CYCLES     (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK_100MHz (CLK_100MHz),
        .RESET_N    (RESET_N),
        .SAMPLE     (but_sync_reg[1]),
        .LEVEL      (but_level)
    );
`else
    assign but_level = but_sync_reg[1];
`endif

    // Only a rising edge of the conditioned level counts, so a held button
    // yields one request.
    assign but_req     = but_level & ~but_prev_reg;
    assign restart_req = SW_REQ | but_req;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_hit
        assign stage_hit[gi] = (idx_reg == IDX_W'(gi));
    end

    assign hold_done  = (state_reg == ASSERT) && rst_sync_reg[1] && (cnt_reg == HOLD_LAST);
    assign gap_done   = (state_reg == RELEASE) && (cnt_reg == GAP_LAST);
    assign last_stage = (idx_reg == IDX_LAST);

    // State register, including the registered outputs.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ASSERT;
            cnt_reg       <= '0;
            idx_reg       <= IDX_W'(STAGE_MEM);
            stage_rst_reg <= '1;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            stage_rst_reg <= stage_rst_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (restart_req) begin
            state_next = ASSERT;
            cnt_next   = '0;
            idx_next   = IDX_W'(STAGE_MEM);
        end else begin
            case (state_reg)
                ASSERT: begin
                    if (hold_done) begin
                        cnt_next = '0;
                        if (NUM_STAGES == 1) begin
                            state_next = RUN;
                        end else begin
                            state_next = RELEASE;
                            idx_next   = IDX_W'(STAGE_CPU);
                        end
                    end else if (rst_sync_reg[0] && (cnt_reg != HOLD_LAST)) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_done) begin
                        cnt_next = '0;
                        if (last_stage) begin
                            state_next = RUN;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        stage_rst_next = stage_rst_reg;
        ready_next     = ready_reg;
        busy_next      = busy_reg;
        if (restart_req) begin
            stage_rst_next = '1;
            ready_next     = 1'b0;
            busy_next      = 1'b1;
        end else if (hold_done || gap_done) begin
            stage_rst_next = stage_rst_reg & ~stage_hit;
            if ((hold_done && NUM_STAGES == 1) || (gap_done && last_stage)) begin
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        end
    end

    assign STAGE_RST = stage_rst_reg;
    assign READY     = ready_reg;
    assign BUSY      = busy_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with NUM_STAGES=3, HOLD=4, GAP=2,
// DEBOUNCE=8; button expectations follow RESET_SEQ_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NS      = 3;
    localparam int H       = 4;
    localparam int G       = 2;
    localparam int D       = 8;
    localparam int SEQ_LEN = H + (NS - 1) * G;
    localparam int IDLE    = 1000;
`ifdef RESET_SEQ_DEBOUNCE_EN
    localparam int BUT_LAT = 2 + D + 1;
    localparam bit DEB_ON  = 1'b1;
`else
    localparam int BUT_LAT = 3;
    localparam bit DEB_ON  = 1'b0;
`endif

    logic          CLK_100MHz = 1'b0;
    logic          RESET_N    = 1'b0;
    logic          BUT        = 1'b0;
    logic          SW_REQ     = 1'b0;
    logic [NS-1:0] STAGE_RST;
    logic          READY;
    logic          BUSY;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 CLK_100MHz = ~CLK_100MHz;

    reset_sequencer #(
        .NUM_STAGES      (NS),
        .HOLD_CYCLES     (H),
        .GAP_CYCLES      (G),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLK_100MHz (CLK_100MHz),
        .RESET_N    (RESET_N),
        .BUT        (BUT),
        .SW_REQ     (SW_REQ),
        .STAGE_RST  (STAGE_RST),
        .READY      (READY),
        .BUSY       (BUSY)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stage s is held while fewer than H + s*G edges have passed since the start edge.
    function automatic logic [NS-1:0] exp_rst(input int k);
        logic [NS-1:0] r;
        for (int s = 0; s < NS; s++) r[s] = (k < H + s * G);
        return r;
    endfunction

    task automatic check_seq(input string tag, input int k);
        $display("%s k=%0d STAGE_RST=%b READY=%b BUSY=%b", tag, k, STAGE_RST, READY, BUSY);
        check_eq({tag, "/rst"},   32'(STAGE_RST), 32'(exp_rst(k)));
        check_eq({tag, "/ready"}, 32'(READY),     32'(k >= SEQ_LEN));
        check_eq({tag, "/busy"},  32'(BUSY),      32'(k < SEQ_LEN));
    endtask

    task automatic tick();
        @(posedge CLK_100MHz);
        #1;
    endtask

    task automatic sw_pulse();
        SW_REQ = 1'b1;
        tick();
        SW_REQ = 1'b0;
    endtask

    // Hold BUT high for 'hold' edges; lat=0 means no restart is expected.
    task automatic run_button(input string tag, input int hold, input int lat, input int total);
        BUT = 1'b1;
        for (int e = 1; e <= total; e++) begin
            tick();
            if (e == hold) BUT = 1'b0;
            if (lat > 0 && e >= lat) check_seq(tag, e - lat);
            else                     check_seq(tag, IDLE);
        end
    endtask

    initial begin
        int rises;
        logic prev_ready;

        // Power-up release order
        repeat (3) tick();
        check_seq("t1_reset", 0);
        RESET_N = 1'b1;
        for (int e = 1; e <= SEQ_LEN + 2; e++) begin
            tick();
            check_seq("t1_pwrup", e - 1);
        end

        // Software request from RUN
        sw_pulse();
        check_seq("t2_sw", 0);
        for (int k = 1; k <= SEQ_LEN + 2; k++) begin
            tick();
            check_seq("t2_sw", k);
        end

        // Restart right after stage 0 releases
        sw_pulse();
        check_seq("t3_first", 0);
        for (int k = 1; k <= H; k++) begin
            tick();
            check_seq("t3_first", k);
        end
        sw_pulse();
        check_seq("t3_restart", 0);
        for (int k = 1; k <= SEQ_LEN + 1; k++) begin
            tick();
            check_seq("t3_restart", k);
        end

        // Requests on consecutive cycles: the last one starts the sequence
        SW_REQ = 1'b1;
        tick();
        check_seq("t3_consec", 0);
        tick();
        SW_REQ = 1'b0;
        check_seq("t3_consec", 0);
        for (int k = 1; k <= SEQ_LEN + 1; k++) begin
            tick();
            check_seq("t3_consec", k);
        end

        // Button: short pulse, then a long hold
        if (DEB_ON) run_button("t4_short", 3, 0, 16);
        else        run_button("t4_short", 3, BUT_LAT, BUT_LAT + SEQ_LEN + 6);
        run_button("t4_hold", 20, BUT_LAT, 36);

        // Asynchronous assertion mid-RELEASE
        sw_pulse();
        for (int k = 1; k <= H + 1; k++) tick();
        check_seq("t5_pre", H + 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check_seq("t5_async", 0);
        tick();
        check_seq("t5_held", 0);
        RESET_N = 1'b1;
        for (int e = 1; e <= SEQ_LEN + 2; e++) begin
            tick();
            check_seq("t5_pwrup", e - 1);
        end

        // Simultaneous software request and button edge
        BUT = 1'b1;
        for (int e = 1; e < BUT_LAT; e++) begin
            tick();
            check_seq("t6_wait", IDLE);
        end
        SW_REQ = 1'b1;
        tick();
        SW_REQ = 1'b0;
        check_seq("t6_both", 0);
        rises      = 0;
        prev_ready = READY;
        for (int k = 1; k <= SEQ_LEN + 6; k++) begin
            tick();
            check_seq("t6_both", k);
            if (READY && !prev_ready) rises++;
            prev_ready = READY;
        end
        BUT = 1'b0;
        for (int e = 1; e <= D + 6; e++) begin
            tick();
            if (READY && !prev_ready) rises++;
            prev_ready = READY;
        end
        check_seq("t6_after", IDLE);
        check_eq("t6_ready_rises", 32'(rises), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-up and on-demand reset controller for the Hack FPGA system. Takes the board-level asynchronous reset plus two runtime reset requesters (front-panel button and CPU software request), and releases an ordered set of per-domain synchronous resets one domain at a time, e.g. memory, then CPU, then I/O. Sits between the clock/reset pins and every downstream block's `RESET` input. It is the single source of all domain resets.

## Interface
Parameters:
- `NUM_STAGES`, default 3: number of reset domains released in order, index 0 first. Must be ≥1.
- `HOLD_CYCLES`, default 16: cycles all stages stay asserted before stage 0 releases. Must be ≥1.
- `GAP_CYCLES`, default 4: cycles between consecutive stage releases. Must be ≥1.
- `DEBOUNCE_CYCLES`, default 1000000: cycles the button must be stable to register. Used only with `RESET_SEQ_DEBOUNCE_EN`.

Ports:
- `CLK_100MHz`, in, 1: system clock. The single clock.
- `RESET_N`, in, 1: asynchronous, active-low master reset.
- `BUT`, in, 1: raw button, active-high, asynchronous to the clock.
- `SW_REQ`, in, 1: single-cycle software reset request, synchronous.
- `STAGE_RST`, out, `NUM_STAGES`: active-high per-domain resets.
- `READY`, out, 1: high when all stages are released.
- `BUSY`, out, 1: high while a sequence is in progress.

## Operation
- FSM states: `ASSERT`, `RELEASE`, `RUN`.
- While `RESET_N` is low, the block holds these values with no clock edge required:
  - state = `ASSERT`, counter = 0, stage index = 0
  - `STAGE_RST` all ones, `READY` = 0, `BUSY` = 1
- `RESET_N` deassertion passes through an internal 2-flop synchronizer. The FSM starts counting on the 2nd edge after `RESET_N` rises.
- `ASSERT`: the counter increments each cycle. At count `HOLD_CYCLES` the block clears `STAGE_RST[0]` and moves to `RELEASE` with index 1, counter 0.
- `RELEASE`: the counter increments each cycle. Every `GAP_CYCLES` it clears `STAGE_RST[index]` and increments the index. When the last stage clears, the state goes to `RUN`, `READY` = 1 and `BUSY` = 0, all on that same edge.
- If `NUM_STAGES` = 1, the FSM goes from `ASSERT` straight to `RUN`.
- Reset request = `SW_REQ` OR a rising edge of the conditioned button level. A request in any state does the following on the next edge:
  - `STAGE_RST` set to all ones, `READY` = 0, `BUSY` = 1
  - state = `ASSERT`, counter = 0, index = 0
  - A request mid-sequence therefore restarts the sequence from the beginning.
- Simultaneous requests, or requests on consecutive cycles, act as one restart each. The last request defines the start of the sequence.
- A button held high produces only one request. A new request needs a release followed by another press.
- Stages are released strictly in ascending index order and never overlap.
- Counter width is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`. The counter does not wrap within a phase.

## Timing
- Outputs assert asynchronously on `RESET_N`. They deassert only on the rising edge of `CLK_100MHz`, registered.
- Measuring from the first edge after the `RESET_N` rise as edge 1:
  - `STAGE_RST[0]` falls at edge 1+`HOLD_CYCLES`.
  - `STAGE_RST[k]` falls at edge 1+`HOLD_CYCLES`+k·`GAP_CYCLES`.
- `SW_REQ` sampled at edge E reasserts all outputs at edge E. Stage 0 then falls at edge E+`HOLD_CYCLES`.
- Button path latency to a request: 2-cycle synchronizer, plus `DEBOUNCE_CYCLES` when debounce is enabled, plus 1-cycle edge detection.

## Configuration
- Macro: `RESET_SEQ_DEBOUNCE_EN`.
- Defined: the synchronized button level passes through the debouncer. The level updates only after `DEBOUNCE_CYCLES` consecutive identical samples.
- Undefined: the synchronized button level feeds edge detection directly. Glitches can then cause requests.

## Structure
- Package `reset_seq_pkg`:
  - FSM state enum
  - stage index constants `STAGE_MEM`=0, `STAGE_CPU`=1, `STAGE_IO`=2
  - default parameter constants
- Sub-module `debounce`: synchronized input, stability counter, debounced level output. Reset by `RESET_N`. Instantiated only under `RESET_SEQ_DEBOUNCE_EN`.

## Test plan
Test parameters: `NUM_STAGES`=3, `HOLD_CYCLES`=4, `GAP_CYCLES`=2, `DEBOUNCE_CYCLES`=8.
1. `RESET_N` low for 3 cycles, then high -> `STAGE_RST`=111 throughout; 011 at edge 5; 001 at edge 7; 000 with `READY`=1 at edge 9.
2. In `RUN`, 1-cycle `SW_REQ` at edge E -> 111, `READY`=0, `BUSY`=1 at E; 000 and `READY`=1 at E+8.
3. `SW_REQ` at the edge right after stage 0 releases -> 111 again; full sequence restarts with the same 4/2/2 spacing.
4. Debounce on: `BUT` high 3 cycles -> no request. `BUT` high 20 cycles -> exactly one restart, 11 edges after the rise. Debounce off: a 3-cycle pulse causes a restart.
5. `RESET_N` driven low mid-`RELEASE` between clock edges -> `STAGE_RST`=111 and `READY`=0 immediately, with no edge.
6. `SW_REQ` and button edge on the same cycle -> a single sequence; `READY` rises exactly once, 8 edges later.
